// File: rtl/seq_mul_pkg.sv
// -----------------------------------------------------------------------------
// seq_mul_pkg
// Shared definitions for the sequential shift-and-add multiplier.
//   - DEFAULT_WIDTH : default operand width
//   - state_e       : controller FSM encoding (IDLE / RUN / DONE)
//   - cnt_w()       : width of the step counter for a given operand width
// No ports (package).
// -----------------------------------------------------------------------------
package seq_mul_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Counter must hold 0..width-1; operand widths start at 2, so this is >= 1.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/seq_mul_ctrl_mul_add_stage.sv
// -----------------------------------------------------------------------------
// mul_add_stage
// Purely combinational DW-bit ripple-carry adder built from full-adder cells.
// When en_i is high the output is acc_i + addend_i, otherwise acc_i.
// Ports:
//   acc_i    [DW-1:0]  running accumulator
//   addend_i [DW-1:0]  shifted multiplicand
//   en_i               add enable (current multiplier bit)
//   sum_o    [DW-1:0]  acc_i + (en_i ? addend_i : 0)
// -----------------------------------------------------------------------------
module mul_add_stage
    import seq_mul_pkg::*;
#(
    parameter int DW = 2 * DEFAULT_WIDTH
) (
    input  logic [DW-1:0] acc_i,
    input  logic [DW-1:0] addend_i,
    input  logic          en_i,
    output logic [DW-1:0] sum_o
);

    logic [DW-1:0] op_b;
    logic [DW-1:0] carry;

    assign op_b     = en_i ? addend_i : '0;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < DW; i++) begin : g_fa
        assign sum_o[i] = acc_i[i] ^ op_b[i] ^ carry[i];
        // The carry out of the top cell is never built: the product always
        // fits in DW bits, so that carry is provably zero.
        if (i < DW - 1) begin : g_carry
            assign carry[i+1] = (acc_i[i] & op_b[i]) | (carry[i] & (acc_i[i] ^ op_b[i]));
        end
    end

endmodule

// File: rtl/seq_mul_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mul_ctrl
// Sequential unsigned multiplier: one partial product per clock through a
// single shared 2*WIDTH-bit adder (mul_add_stage), with valid/ready handshakes
// on the operand and result sides.
//
// Optional feature macro: SEQ_MUL_EARLY_TERM_EN
//   defined   : RUN ends as soon as the remaining multiplier bits are all zero
//               (RUN length = max(1, index of MSB set in b + 1)).
//   undefined : RUN always lasts exactly WIDTH cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; aborts any operation
//   in_valid   operand pair presented
//   in_ready   operands can be accepted (high only in IDLE)
//   a, b       [WIDTH-1:0] unsigned multiplicand / multiplier
//   out_valid  product available (DONE)
//   out_ready  consumer accepts product
//   p          [2*WIDTH-1:0] product a*b, stable while out_valid is high
//   busy       high in RUN or DONE
// -----------------------------------------------------------------------------
module seq_mul_ctrl
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [PW-1:0]      p_q;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, out_valid_q, busy_q;
    logic               last_step;

    // acc_d is acc_q + mcand_q when the current multiplier bit is set.
    mul_add_stage #(.DW(PW)) u_add (
        .acc_i    (acc_q),
        .addend_i (mcand_q),
        .en_i     (mplier_q[0]),
        .sum_o    (acc_d)
    );

    // NOTE: every signal in this block is assigned on every path, so no latch
    // can be inferred.
    always_comb begin
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
`ifdef SEQ_MUL_EARLY_TERM_EN
        // Stop once no set multiplier bits remain; the counter bound still
        // holds and makes the WIDTH-cycle maximum explicit.
        last_step = (cnt_q == CNT_LAST) || (mplier_d == '0);
`else
        last_step = (cnt_q == CNT_LAST);
`endif
    end

    // NOTE: reset is sampled on the clock edge and every register, including
    // the datapath, is cleared so an aborted operation leaves no residue;
    // state updates use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand_q    <= PW'(a);
                        mplier_q   <= b;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_d;
                    if (last_step) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        p_q         <= acc_d;
                    end
                end
                S_DONE: begin
                    // Going back through IDLE means no accept can coincide
                    // with the result handshake.
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign p         = p_q;

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_mul_ctrl
// Directed self-checking bench for seq_mul_ctrl at WIDTH=3.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// Latency is counted in rising edges after the accept edge (WIDTH edges for the
// fixed-latency build, max(1, MSB index of b + 1) with SEQ_MUL_EARLY_TERM_EN).
// -----------------------------------------------------------------------------
module tb_seq_mul_ctrl;
    import seq_mul_pkg::*;

    localparam int W   = 3;
    localparam int PW  = 2 * W;
    localparam int LIM = 40;

    logic          clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0]  a, b;
    logic [PW-1:0] p;

    int checks   = 0;
    int failures = 0;

    seq_mul_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    function automatic int exp_lat(input logic [W-1:0] bv);
        int n;
        n = W;
`ifdef SEQ_MUL_EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < W; i++) if (bv[i]) n = i + 1;
`else
        if (bv == '1) n = W;
`endif
        return n;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Edges until out_valid is seen, capped at LIM (a cap shows up as a wrong latency).
    task automatic wait_out_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < LIM) begin
            tick();
            lat++;
        end
    endtask

    // One complete operation from IDLE: accept, wait for result, handshake.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [PW-1:0] pv, output int lat);
        out_ready = 1'b1;
        a = av; b = bv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = ~av; b = ~bv;
        wait_out_valid(lat);
        pv = p;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; a = 3'd5; b = 3'd5; out_ready = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (p !== 6'd0) begin failures++; $display("FAIL reset_p got=%0d exp=0", p); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_basic;
        int lat;
        out_ready = 1'b1; a = 3'd5; b = 3'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = 3'd0; b = 3'd0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_drop got=%0b exp=0", in_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b exp=0", out_valid); end
        wait_out_valid(lat);
        checks++; if (lat != exp_lat(3'd7)) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, exp_lat(3'd7)); end
        checks++; if (p !== 6'd35) begin failures++; $display("FAIL basic_p got=%0d exp=35", p); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_done got=%0b exp=0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready_back got=%0b exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_drop got=%0b exp=0", busy); end
    endtask

    task automatic test_zero_and_max;
        logic [PW-1:0] pv;
        int lat;
        do_op(3'd6, 3'd0, pv, lat);
        checks++; if (pv !== 6'd0) begin failures++; $display("FAIL zero_b_p got=%0d exp=0", pv); end
        checks++; if (lat != exp_lat(3'd0)) begin failures++; $display("FAIL zero_b_latency got=%0d exp=%0d", lat, exp_lat(3'd0)); end
        do_op(3'd0, 3'd5, pv, lat);
        checks++; if (pv !== 6'd0) begin failures++; $display("FAIL zero_a_p got=%0d exp=0", pv); end
        do_op(3'd7, 3'd7, pv, lat);
        checks++; if (pv !== 6'd49) begin failures++; $display("FAIL max_p got=%0d exp=49", pv); end
        do_op(3'd3, 3'd1, pv, lat);
        checks++; if (pv !== 6'd3) begin failures++; $display("FAIL one_b_p got=%0d exp=3", pv); end
        checks++; if (lat != exp_lat(3'd1)) begin failures++; $display("FAIL one_b_latency got=%0d exp=%0d", lat, exp_lat(3'd1)); end
    endtask

    task automatic test_sweep;
        logic [PW-1:0] pv;
        logic [PW-1:0] pe;
        int lat;
        for (int ai = 0; ai < 8; ai++) begin
            for (int bi = 0; bi < 8; bi++) begin
                do_op(3'(ai), 3'(bi), pv, lat);
                pe = PW'(ai * bi);
                checks++; if (pv !== pe) begin failures++; $display("FAIL sweep_p a=%0d b=%0d got=%0d exp=%0d", ai, bi, pv, pe); end
                checks++; if (lat != exp_lat(3'(bi))) begin failures++; $display("FAIL sweep_latency a=%0d b=%0d got=%0d exp=%0d", ai, bi, lat, exp_lat(3'(bi))); end
            end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready = 1'b0; a = 3'd3; b = 3'd6; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out_valid(lat);
        checks++; if (lat != exp_lat(3'd6)) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, exp_lat(3'd6)); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; a = 3'(i); b = 3'd1;
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%0b exp=1", i, out_valid); end
            checks++; if (p !== 6'd18) begin failures++; $display("FAIL bp_hold_p cyc=%0d got=%0d exp=18", i, p); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", i, in_ready); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%0b exp=1", in_ready); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_ignored_input busy got=%0b exp=0", busy); end
    endtask

    task automatic test_reset_mid_run;
        logic [PW-1:0] pv;
        int lat;
        out_ready = 1'b1; a = 3'd7; b = 3'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid got=%0b exp=0", out_valid); end
        checks++; if (p !== 6'd0) begin failures++; $display("FAIL abort_p got=%0d exp=0", p); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready got=%0b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_no_result got=%0b exp=0", out_valid); end
        do_op(3'd2, 3'd3, pv, lat);
        checks++; if (pv !== 6'd6) begin failures++; $display("FAIL abort_next_p got=%0d exp=6", pv); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0]  va [4];
        logic [W-1:0]  vb [4];
        logic [PW-1:0] ve [4];
        int lat;
        va = '{3'd1, 3'd3, 3'd7, 3'd4};
        vb = '{3'd2, 3'd3, 3'd6, 3'd5};
        ve = '{6'd2, 6'd9, 6'd42, 6'd20};
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = va[k]; b = vb[k];
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready op=%0d got=%0b exp=1", k, in_ready); end
            tick();
            // Operands change while in_valid stays high; they must be ignored.
            a = va[k] ^ 3'b101; b = vb[k] + 3'd1;
            wait_out_valid(lat);
            checks++; if (p !== ve[k]) begin failures++; $display("FAIL b2b_p op=%0d got=%0d exp=%0d", k, p, ve[k]); end
            checks++; if (lat != exp_lat(vb[k])) begin failures++; $display("FAIL b2b_latency op=%0d got=%0d exp=%0d", k, lat, exp_lat(vb[k])); end
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_end got=%0b exp=0", busy); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_zero_and_max();
        test_sweep();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
